// File: rtl/sram_ctrl_pkg.sv
// Shared types and limits for the byte-wide SRAM controller and its arbiter.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD
  } state_t;

  localparam int WAIT_CNT_W   = 4;
  localparam int STARVE_CNT_W = 8;

  localparam int MAX_NUM_CH       = 8;
  localparam int MAX_WAIT_CYCLES  = 15;
  localparam int MAX_STARVE_LIMIT = 255;

endpackage

// File: rtl/sram_port_arbiter.sv
// Fixed-priority arbiter between NUM_CH read channels and the Wishbone port
// (grant bit NUM_CH), with a starvation override that favours Wishbone.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idle,
  input  logic              stb,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [NUM_CH:0]   grant,
  output logic              grant_valid
);

  localparam int WB_IDX = NUM_CH;
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  localparam bit OVERRIDE_EN = (STARVE_LIMIT != 0);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starve_hit;
  logic                    found;

  assign starve_hit  = OVERRIDE_EN && (starve_cnt == LIMIT);
  assign grant_valid = |grant;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (idle) begin
      if (stb && starve_hit) begin
        grant[WB_IDX] = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch_req[k] && !found) begin
            grant[k] = 1'b1;
            found    = 1'b1;
          end
        end
        if (!found && stb) grant[WB_IDX] = 1'b1;
      end
    end
  end

  // Counts channel wins that happen while Wishbone is left waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!stb || grant[WB_IDX]) begin
      starve_cnt <= '0;
    end else if (grant_valid && starve_cnt != '1) begin
      starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_wb8_multiport.sv
// Byte-wide asynchronous SRAM controller shared by a Wishbone pipelined slave
// and NUM_CH read-only priority channels; one access is in flight at a time.
module sram_wb8_multiport
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int NUM_CH       = 2,
  parameter int WAIT_CYCLES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_N_I,
  input  logic                     STB_I,
  input  logic                     WE_I,
  input  logic [ADDR_W-1:0]        ADR_I,
  input  logic [7:0]               DAT_I,
  output logic [7:0]               DAT_O,
  output logic                     ACK_O,
  output logic                     STALL_O,
  input  logic [NUM_CH-1:0]        CH_REQ_I,
  input  logic [NUM_CH*ADDR_W-1:0] CH_ADR_I,
  output logic [NUM_CH-1:0]        CH_ACK_O,
  output logic [7:0]               CH_DAT_O,
  input  logic [7:0]               I_data,
  output logic [7:0]               O_data,
  output logic [ADDR_W-1:0]        O_address,
  output logic                     O_ce,
  output logic                     O_oe,
  output logic                     O_we,
  output logic                     O_output_enable
);

  localparam int WB_IDX = NUM_CH;

  state_t                state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [NUM_CH:0]       grant;
  logic [NUM_CH:0]       owner;
  logic                  grant_valid;
  logic                  idle;
  logic                  acc_we;
  logic                  access_done;
  logic [ADDR_W-1:0]     grant_addr;

  assign idle        = (state == IDLE);
  assign access_done = (state == ACTIVE) && (wait_cnt == '0);

  sram_port_arbiter #(
    .NUM_CH      (NUM_CH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbiter (
    .clk        (CLK_I),
    .rst_n      (RST_N_I),
    .idle       (idle),
    .stb        (STB_I),
    .ch_req     (CH_REQ_I),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  // The arbiter only grants in IDLE, so a Wishbone grant bit means accept.
  assign STALL_O = STB_I & ~grant[WB_IDX];

  always_comb begin
    grant_addr = ADR_I;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) grant_addr = CH_ADR_I[k*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = SETUP;
      SETUP:   state_next = ACTIVE;
      ACTIVE:  if (access_done) state_next = acc_we ? HOLD : IDLE;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode from the registered state so reset releases them at once.
  always_comb begin
    O_ce            = ~RST_N_I;
    O_oe            = 1'b1;
    O_we            = 1'b1;
    O_output_enable = 1'b0;
    case (state)
      SETUP: begin
        O_oe            = acc_we;
        O_output_enable = acc_we;
      end
      ACTIVE: begin
        O_oe            = acc_we;
        O_we            = ~acc_we;
        O_output_enable = acc_we;
      end
      HOLD:    O_output_enable = acc_we;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      O_address <= '0;
      O_data    <= '0;
      owner     <= '0;
      acc_we    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (idle && grant_valid) begin
        O_address <= grant_addr;
        owner     <= grant;
        acc_we    <= grant[WB_IDX] & WE_I;
        if (grant[WB_IDX]) O_data <= DAT_I;
      end
      if (state == SETUP) begin
        wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
      end else if (state == ACTIVE && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
      end
    end
  end

  // Completion pulses land in the IDLE cycle that follows the access.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ACK_O    <= 1'b0;
      CH_ACK_O <= '0;
      DAT_O    <= '0;
      CH_DAT_O <= '0;
    end else begin
      ACK_O    <= 1'b0;
      CH_ACK_O <= '0;
      if (access_done && !acc_we) begin
        if (owner[WB_IDX]) begin
          ACK_O <= 1'b1;
          DAT_O <= I_data;
        end else begin
          CH_ACK_O <= owner[NUM_CH-1:0];
          CH_DAT_O <= I_data;
        end
      end
      if (state == HOLD) ACK_O <= 1'b1;
    end
  end

endmodule
